// File: rtl/cordic_iter_param.sv
`default_nettype none
// ============================================================================
// Module  : cordic_iter_param
// Brief   : Iterative rotation/vectoring CORDIC, one micro-rotation per clock
// Revision: 1.0
// ============================================================================
module cordic_iter_param #(
  parameter int N_BIT = 12,
  parameter int GUARD = 4,
  parameter int ITER  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [N_BIT+GUARD-1:0] in_x,
  input  logic [N_BIT+GUARD-1:0] in_y,
  input  logic [N_BIT-1:0]       in_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_BIT+GUARD-1:0] out_x,
  output logic [N_BIT+GUARD-1:0] out_y,
  output logic [N_BIT-1:0]       out_z
);

  localparam int c_w         = N_BIT + GUARD;
  localparam int c_iw        = $clog2(ITER);
  localparam int c_rom_shift = 32 - N_BIT;
  localparam logic [c_iw-1:0] c_last = c_iw'(ITER - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  // atan(2^-i) at 2^-30 rad resolution
  function automatic logic [31:0] atan_rom(input int idx);
    case (idx)
      0:       return 32'd843314856;
      1:       return 32'd497837829;
      2:       return 32'd263043836;
      3:       return 32'd133525158;
      4:       return 32'd67021686;
      5:       return 32'd33543515;
      6:       return 32'd16775850;
      7:       return 32'd8388437;
      8:       return 32'd4194282;
      9:       return 32'd2097149;
      10:      return 32'd1048575;
      11:      return 32'd524287;
      12:      return 32'd262143;
      13:      return 32'd131071;
      14:      return 32'd65535;
      15:      return 32'd32767;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [N_BIT-1:0] atan_scaled(input int idx);
    logic [32:0] v;
    v = {1'b0, atan_rom(idx)} + (33'd1 << (c_rom_shift - 1));
    v = v >> c_rom_shift;
    return v[N_BIT-1:0];
  endfunction

  logic [N_BIT-1:0] w_atan_tab [2**c_iw];

  for (genvar g = 0; g < 2**c_iw; g++) begin : g_atan
    assign w_atan_tab[g] = atan_scaled(g);
  end

  logic [1:0]              r_state, w_state_nxt;
  logic signed [c_w-1:0]   r_x, r_y, w_x_nxt, w_y_nxt, w_x_sh, w_y_sh;
  logic signed [N_BIT-1:0] r_z, w_z_nxt, w_atan;
  logic                    r_mode, w_dir_pos, w_last;
  logic [c_iw-1:0]         r_iter;
  logic [c_w-1:0]          r_out_x, r_out_y;
  logic [N_BIT-1:0]        r_out_z;

  assign w_last = (r_state == c_run) && (r_iter == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (in_valid)  w_state_nxt = c_run;
      c_run:   if (w_last)    w_state_nxt = c_done;
      c_done:  if (out_ready) w_state_nxt = c_idle;
      default:                w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_idle);
    out_valid = (r_state == c_done);
  end

  // Rotation steers z toward 0, vectoring steers y toward 0
  always_comb begin
    w_x_sh    = r_x >>> r_iter;
    w_y_sh    = r_y >>> r_iter;
    w_atan    = $signed(w_atan_tab[r_iter]);
    w_dir_pos = r_mode ? r_y[c_w-1] : ~r_z[N_BIT-1];
    if (w_dir_pos) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_mode  <= 1'b0;
      r_iter  <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_out_z <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_x    <= in_x;
            r_y    <= in_y;
            r_z    <= in_z;
            r_mode <= in_mode;
            r_iter <= '0;
          end
        end
        c_run: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + c_iw'(1);
          if (w_last) begin
            r_out_x <= w_x_nxt;
            r_out_y <= w_y_nxt;
            r_out_z <= w_z_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_x = r_out_x;
  assign out_y = r_out_y;
  assign out_z = r_out_z;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_param.sv
`default_nettype none
// Bench for cordic_iter_param: default instance for directed cases, and a
// 16-bit/14-iteration instance for a random rotation sweep against a real model.
module tb_cordic_iter_param;

  localparam int N0 = 12, W0 = 16, I0 = 10;
  localparam int N1 = 16, W1 = 20, I1 = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v0, rdy0, mode0, ov0, ordy0;
  logic [W0-1:0] x0, y0, ox0, oy0;
  logic [N0-1:0] z0, oz0;
  logic          v1, rdy1, mode1, ov1, ordy1;
  logic [W1-1:0] x1, y1, ox1, oy1;
  logic [N1-1:0] z1, oz1;

  cordic_iter_param dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_mode(mode0),
    .in_x(x0), .in_y(y0), .in_z(z0), .out_valid(ov0), .out_ready(ordy0),
    .out_x(ox0), .out_y(oy0), .out_z(oz0)
  );

  cordic_iter_param #(.N_BIT(16), .GUARD(4), .ITER(14)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_mode(mode1),
    .in_x(x1), .in_y(y1), .in_z(z1), .out_valid(ov1), .out_ready(ordy1),
    .out_x(ox1), .out_y(oy1), .out_z(oz1)
  );

  typedef struct {
    int ex;
    int ey;
    int ez;
    int acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  logic ov0_q   = 1'b0;
  logic ov1_q   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint expv,
                       input longint tol = 0);
    longint diff;
    diff = obs - expv;
    if (diff < 0) diff = -diff;
    n_total++;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", tag, obs, expv, tol, cyc);
    end
  endtask

  // Real-valued CORDIC: exact angle bookkeeping with a rounded atan table,
  // untruncated x/y arithmetic.
  function automatic void model(input int nb, input int it, input bit mode,
                                input int x, input int y, input int z,
                                output int ex, output int ey, output int ez);
    real xr, yr, xn, sc;
    int  zi, tab;
    bit  dpos;
    xr = x;
    yr = y;
    zi = z;
    for (int k = 0; k < it; k++) begin
      tab  = $rtoi($atan(2.0 ** (-k)) * (2.0 ** (nb - 2)) + 0.5);
      sc   = 2.0 ** (-k);
      dpos = mode ? (yr < 0.0) : (zi >= 0);
      if (dpos) begin
        xn = xr - yr * sc;
        yr = yr + xr * sc;
        zi = zi - tab;
      end else begin
        xn = xr + yr * sc;
        yr = yr - xr * sc;
        zi = zi + tab;
      end
      xr = xn;
      zi = (zi <<< (32 - nb)) >>> (32 - nb);
    end
    ex = $rtoi((xr >= 0.0) ? xr + 0.5 : xr - 0.5);
    ey = $rtoi((yr >= 0.0) ? yr + 0.5 : yr - 0.5);
    ez = zi;
  endfunction

  // Scoreboards: latency on out_valid rise, values on each output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0 && !ov0_q && q0.size() > 0) check("lat0", cyc - q0[0].acc, I0);
      if (ov0 && ordy0) begin
        if (q0.size() == 0) check("unexp_out0", 1, 0);
        else begin
          exp_t e;
          e = q0.pop_front();
          check("x0", $signed(ox0), e.ex, I0);
          check("y0", $signed(oy0), e.ey, I0);
          check("z0", $signed(oz0), e.ez, 2);
        end
      end
      if (ov1 && !ov1_q && q1.size() > 0) check("lat1", cyc - q1[0].acc, I1);
      if (ov1 && ordy1) begin
        if (q1.size() == 0) check("unexp_out1", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("x1", $signed(ox1), e.ex, I1);
          check("y1", $signed(oy1), e.ey, I1);
          check("z1", $signed(oz1), e.ez, 2);
        end
      end
    end
    ov0_q <= ov0;
    ov1_q <= ov1;
  end

  task automatic send0(input bit mode, input int x, input int y, input int z);
    exp_t e;
    int   ex, ey, ez;
    bit   ok;
    ok = 1'b0;
    model(N0, I0, mode, x, y, z, ex, ey, ez);
    e.ex = ex; e.ey = ey; e.ez = ez;
    mode0 = mode; x0 = W0'(x); y0 = W0'(y); z0 = N0'(z); v0 = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (rdy0) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1;
    v0    = 1'b0;
    mode0 = ~mode;
    if (!ok) check("accept0_timeout", 0, 1);
    else begin
      e.acc = cyc;
      q0.push_back(e);
    end
  endtask

  task automatic send1(input bit mode, input int x, input int y, input int z,
                       output int acc);
    exp_t e;
    int   ex, ey, ez;
    bit   ok;
    ok  = 1'b0;
    acc = -1;
    model(N1, I1, mode, x, y, z, ex, ey, ez);
    e.ex = ex; e.ey = ey; e.ez = ez;
    mode1 = mode; x1 = W1'(x); y1 = W1'(y); z1 = N1'(z); v1 = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (rdy1) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1;
    if (!ok) check("accept1_timeout", 0, 1);
    else begin
      e.acc = cyc;
      acc   = cyc;
      q1.push_back(e);
    end
  endtask

  task automatic drain(input bit which);
    for (int t = 0; t < 200 && ((which ? q1.size() : q0.size()) > 0); t++) @(posedge clk);
    if (which ? q1.size() > 0 : q0.size() > 0) begin
      check(which ? "drain1_timeout" : "drain0_timeout", which ? q1.size() : q0.size(), 0);
      if (which) q1.delete();
      else       q0.delete();
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   acc, prev_acc;
    rst_n = 1'b0;
    v0 = 1'b0; mode0 = 1'b0; x0 = '0; y0 = '0; z0 = '0; ordy0 = 1'b1;
    v1 = 1'b0; mode1 = 1'b0; x1 = '0; y1 = '0; z1 = '0; ordy1 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready0", rdy0, 1);
    check("rst_out_valid0", ov0, 0);
    check("rst_out_x0", ox0, 0);
    check("rst_out_y0", oy0, 0);
    check("rst_out_z0", oz0, 0);
    check("rst_in_ready1", rdy1, 1);
    check("rst_out_valid1", ov1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed rotation and vectoring at default parameters
    send0(1'b0, 9950, 0, 0);        drain(1'b0);
    send0(1'b0, 9950, 0, 804);      drain(1'b0);
    send0(1'b0, 9950, 0, -804);     drain(1'b0);
    send0(1'b1, 8192, 8192, 0);     drain(1'b0);
    send0(1'b1, 8192, -8192, 0);    drain(1'b0);
    send0(1'b0, 4000, -3000, -1500); drain(1'b0);

    // Backpressure: DONE held, outputs stable, new operands ignored
    ordy0 = 1'b0;
    send0(1'b0, 9950, 0, 804);
    for (int t = 0; t < 50 && !ov0; t++) @(negedge clk);
    check("bp_valid_rise", ov0, 1);
    e = (q0.size() > 0) ? q0[0] : '{0, 0, 0, 0};
    v0 = 1'b1; mode0 = 1'b1; x0 = W0'(1234); y0 = W0'(-777); z0 = N0'(300);
    repeat (20) begin
      @(negedge clk);
      check("bp_out_valid", ov0, 1);
      check("bp_in_ready", rdy0, 0);
      check("bp_x", $signed(ox0), e.ex, I0);
      check("bp_y", $signed(oy0), e.ey, I0);
      check("bp_z", $signed(oz0), e.ez, 2);
    end
    @(posedge clk);
    #1 v0 = 1'b0; ordy0 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", rdy0, 1);
    check("bp_release_out_valid", ov0, 0);
    if (q0.size() > 0) begin
      check("bp_result_popped", q0.size(), 0);
      q0.delete();
    end

    // Reset in the middle of RUN discards the transaction
    send0(1'b0, 9950, 0, 804);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", rdy0, 1);
    check("midrst_out_valid", ov0, 0);
    check("midrst_out_x", ox0, 0);
    check("midrst_out_y", oy0, 0);
    check("midrst_out_z", oz0, 0);
    q0.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send0(1'b0, 9950, 0, 0);
    drain(1'b0);

    // Random rotation sweep, in_valid held high with out_ready tied high
    prev_acc = -1;
    for (int k = 0; k < 20; k++) begin
      send1(1'b0, int'($urandom_range(0, 131070)) - 65535,
                  int'($urandom_range(0, 131070)) - 65535,
                  int'($urandom_range(0, 49152)) - 24576, acc);
      if (prev_acc >= 0 && acc >= 0) check("throughput1", acc - prev_acc, I1 + 2);
      prev_acc = acc;
    end
    v1 = 1'b0;
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
